lsu_mem_stage: RTL and testbench



---
 rtl/lsu_mem_stage.sv | 133 +++++++++++++
 tb/tb_lsu_mem_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: rv32i MEM stage, req/gnt/rvalid data-memory access with load formatting and writeback register.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being aligned down.
module lsu_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    output logic        lsu_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d, rw_q, rw_d, mis_q, mis_d;
    logic        is_b, is_h, mem, trap, accept, sgn;
    logic [1:0]  off;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val;

    assign is_b   = ex_funct3[1:0] == 2'b00;
    assign is_h   = ex_funct3[1:0] == 2'b01;
    assign mem    = ex_load || ex_store;
    assign accept = ex_valid && (state_q == IDLE || state_q == DONE);
    // Lane offset already aligned down to the access size
    assign off    = is_b ? ex_addr[1:0] : is_h ? {ex_addr[1], 1'b0} : 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap   = mem && (is_h ? ex_addr[0] : !is_b && ex_addr[1:0] != 2'b00);
`else
    assign trap   = 1'b0;
`endif

    assign sgn    = !f3_q[2];
    assign ld_b   = dmem_rdata[{off_q, 3'b000} +: 8];
    assign ld_h   = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign ld_val = f3_q[1:0] == 2'b00 ? {{24{sgn && ld_b[7]}}, ld_b}
                  : f3_q[1:0] == 2'b01 ? {{16{sgn && ld_h[15]}}, ld_h} : dmem_rdata;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_data_d = wb_data_q;
        be_d      = be_q;
        f3_d      = f3_q;
        off_d     = off_q;
        rd_d      = rd_q;
        we_d      = we_q;
        rw_d      = rw_q;
        mis_d     = mis_q;
        if (state_q == DONE) state_d = IDLE;
        if (accept) begin
            addr_d    = {ex_addr[31:2], 2'b00};
            be_d      = is_b ? 4'b0001 << ex_addr[1:0] : is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            wdata_d   = is_b ? {4{ex_wdata[7:0]}} : is_h ? {2{ex_wdata[15:0]}} : ex_wdata;
            we_d      = ex_store && !ex_load;
            f3_d      = ex_funct3;
            off_d     = off;
            rd_d      = ex_rd;
            rw_d      = ex_regwrite && !(ex_store && !ex_load) && !trap;
            mis_d     = trap;
            wb_data_d = ex_addr;
            state_d   = (!mem || trap) ? DONE : REQ;
        end
        if (state_q == REQ && dmem_gnt) state_d = we_q ? DONE : WAIT;
        if (state_q == WAIT && dmem_rvalid) begin
            wb_data_d = ld_val;
            state_d   = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            be_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            rw_q      <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_data_q <= wb_data_d;
            be_q      <= be_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            rw_q      <= rw_d;
            mis_q     <= mis_d;
        end
    end

    assign lsu_stall    = state_q == REQ || state_q == WAIT;
    assign dmem_req     = state_q == REQ;
    assign dmem_we      = dmem_req && we_q;
    assign dmem_be      = be_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = state_q == DONE;
    assign wb_regwrite  = wb_valid && rw_q;
    assign wb_rd        = rd_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = wb_valid && mis_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed vectors for lsu_mem_stage, expected values hand-computed.
module tb_lsu_mem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0, ex_regwrite = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_addr = '0, ex_wdata = '0;
    logic [4:0]  ex_rd = '0;
    logic        lsu_stall, dmem_req, dmem_we, wb_valid, wb_regwrite, misalign_err;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [4:0]  wb_rd;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    int          n_vec = 0, n_err = 0;

    lsu_mem_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .lsu_stall(lsu_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .misalign_err(misalign_err)
    );

    always #5 clk = !clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp, input logic [3:0] exp_be);
        ex_valid = 1; ex_load = 1; ex_store = 0; ex_funct3 = f3; ex_addr = a; ex_rd = 7; ex_regwrite = 1;
        tick();
        ex_valid = 0; ex_load = 0;
        check({tag, " req"}, dmem_req, 1);
        check({tag, " we"}, dmem_we, 0);
        check({tag, " be"}, dmem_be, exp_be);
        check({tag, " addr"}, dmem_addr, {a[31:2], 2'b00});
        dmem_gnt = 1;
        tick();
        dmem_gnt = 0;
        check({tag, " wait stall"}, lsu_stall, 1);
        check({tag, " wait req"}, dmem_req, 0);
        dmem_rvalid = 1; dmem_rdata = word;
        tick();
        dmem_rvalid = 0;
        check({tag, " wb_valid"}, wb_valid, 1);
        check({tag, " wb_data"}, wb_data, exp);
        check({tag, " wb_rd"}, wb_rd, 7);
        check({tag, " wb_regwrite"}, wb_regwrite, 1);
        tick();
        check({tag, " idle"}, wb_valid, 0);
    endtask

    initial begin
        repeat (2) tick();
        rst = 0;
        check("rst wb_valid", wb_valid, 0);
        check("rst req", dmem_req, 0);
        check("rst stall", lsu_stall, 0);
        check("rst be", dmem_be, 0);
        check("rst addr", dmem_addr, 0);
        check("rst wb_data", wb_data, 0);
        check("rst misalign", misalign_err, 0);

        ex_valid = 1; ex_addr = 32'h0000_1234; ex_rd = 5; ex_regwrite = 1;
        tick();
        ex_valid = 0;
        check("alu wb_valid", wb_valid, 1);
        check("alu wb_data", wb_data, 32'h1234);
        check("alu wb_rd", wb_rd, 5);
        check("alu regwrite", wb_regwrite, 1);
        check("alu req", dmem_req, 0);
        tick();
        check("alu pulse", wb_valid, 0);

        ex_valid = 1; ex_store = 1; ex_funct3 = 3'b000; ex_addr = 32'h103; ex_wdata = 32'hAB;
        ex_rd = 0; ex_regwrite = 0;
        tick();
        ex_valid = 0; ex_store = 0;
        for (int i = 0; i < 3; i++) begin
            check("sb req", dmem_req, 1);
            check("sb we", dmem_we, 1);
            check("sb addr", dmem_addr, 32'h100);
            check("sb be", dmem_be, 4'b1000);
            check("sb wdata", dmem_wdata, 32'hABABABAB);
            check("sb stall", lsu_stall, 1);
            tick();
        end
        dmem_gnt = 1;
        tick();
        dmem_gnt = 0;
        check("sb wb_valid", wb_valid, 1);
        check("sb regwrite", wb_regwrite, 0);
        check("sb stall off", lsu_stall, 0);
        check("sb req off", dmem_req, 0);
        tick();

        do_load("lb 201", 3'b000, 32'h201, 32'h80FF_7F01, 32'h0000_007F, 4'b0010);
        do_load("lb 203", 3'b000, 32'h203, 32'h80FF_7F01, 32'hFFFF_FF80, 4'b1000);
        do_load("lbu 203", 3'b100, 32'h203, 32'h80FF_7F01, 32'h0000_0080, 4'b1000);
        do_load("lhu 202", 3'b101, 32'h202, 32'h80FF_7F01, 32'h0000_80FF, 4'b1100);
        do_load("lh 202", 3'b001, 32'h202, 32'h80FF_7F01, 32'hFFFF_80FF, 4'b1100);
        do_load("lhu 200", 3'b101, 32'h200, 32'h80FF_7F01, 32'h0000_7F01, 4'b0011);
        do_load("lw 200", 3'b010, 32'h200, 32'h80FF_7F01, 32'h80FF_7F01, 4'b1111);
        do_load("f3 011", 3'b011, 32'h200, 32'h1234_5678, 32'h1234_5678, 4'b1111);

        ex_valid = 1; ex_load = 1; ex_funct3 = 3'b010; ex_addr = 32'h200; ex_rd = 9; ex_regwrite = 1;
        tick();
        ex_valid = 0; ex_load = 0; dmem_gnt = 1;
        tick();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_rvalid = 0;
        ex_valid = 1; ex_addr = 32'h55; ex_rd = 3; ex_regwrite = 1;
        check("b2b load wb_valid", wb_valid, 1);
        check("b2b load data", wb_data, 32'hCAFE_F00D);
        check("b2b load rd", wb_rd, 9);
        tick();
        ex_valid = 0;
        check("b2b alu wb_valid", wb_valid, 1);
        check("b2b alu data", wb_data, 32'h55);
        check("b2b alu rd", wb_rd, 3);
        tick();
        check("b2b idle", wb_valid, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        ex_valid = 1; ex_load = 1; ex_funct3 = 3'b010; ex_addr = 32'h102; ex_rd = 4; ex_regwrite = 1;
        tick();
        ex_valid = 0; ex_load = 0;
        check("mis req", dmem_req, 0);
        check("mis err", misalign_err, 1);
        check("mis wb_valid", wb_valid, 1);
        check("mis regwrite", wb_regwrite, 0);
        tick();
        check("mis pulse", misalign_err, 0);
`else
        do_load("lw 102", 3'b010, 32'h102, 32'h1122_3344, 32'h1122_3344, 4'b1111);
        check("mis err tied", misalign_err, 0);
`endif

        ex_valid = 1; ex_load = 1; ex_funct3 = 3'b010; ex_addr = 32'h300; ex_rd = 6; ex_regwrite = 1;
        tick();
        ex_valid = 0; ex_load = 0; dmem_gnt = 1;
        tick();
        dmem_gnt = 0;
        check("pre-rst stall", lsu_stall, 1);
        rst = 1;
        tick();
        rst = 0;
        check("mid rst stall", lsu_stall, 0);
        check("mid rst req", dmem_req, 0);
        check("mid rst be", dmem_be, 0);
        check("mid rst addr", dmem_addr, 0);
        check("mid rst wb_valid", wb_valid, 0);
        check("mid rst wb_data", wb_data, 0);
        dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid = 0;
        check("stale rvalid", wb_valid, 0);
        tick();
        check("stale rvalid 2", wb_valid, 0);
        check("stale wb_data", wb_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
